tape_biphase_reader: RTL and testbench

//   Decodes the sliced tape-input bit (the comparator output of the sound codec

---
 rtl/tape_biphase_reader.sv | 198 +++++++++++++++++++
 tb/tb_tape_biphase_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_biphase_reader.sv
// Biphase tape read decoder: synchronises and de-glitches the sliced tape level,
// classifies edge intervals, recovers cell phase, hunts for sync and frames bytes.
`timescale 1ns/1ps
module tape_biphase_reader #(
    parameter int         HALF_CYC  = 7500,
    parameter int         GLITCH    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hE6
) (
    input  logic       clk18,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       tapein,
    input  logic       byte_ack,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       overrun,
    output logic       locked,
    output logic       sync_lost
);

    localparam logic [15:0] T_MIN = 16'(HALF_CYC / 2);
    localparam logic [15:0] T_SL  = 16'(3 * HALF_CYC / 2);
    localparam logic [15:0] T_MAX = 16'(5 * HALF_CYC / 2);
    localparam int          GW    = (GLITCH > 1) ? $clog2(GLITCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HUNT_PHASE,
        S_HUNT_SYNC,
        S_DATA
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic          sync_p0, sync_p1;
    logic          filt_p2, filt_p3;
    logic [GW-1:0] gcnt_p2;
    logic [15:0]   ic_q;
    logic          edge_det;
    logic          is_short, is_long, fault;
    logic          phase_q, phase_step, phase_d;
    logic          emit, bit_in;
    state_t        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d, byte_next;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          invert_q, invert_d;
    logic          byte_done, lost_d;

    // stage p0/p1: two-flop synchroniser; p2: glitch filter; p3: edge reference
    always_ff @(posedge clk18 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            filt_p2 <= 1'b0;
            filt_p3 <= 1'b0;
            gcnt_p2 <= '0;
            ic_q    <= 16'd0;
        end else begin
            sync_p0 <= tapein;
            sync_p1 <= sync_p0;
            filt_p3 <= filt_p2;
            if (sync_p1 != filt_p2) begin
                if (gcnt_p2 == GW'(GLITCH - 1)) begin
                    filt_p2 <= sync_p1;
                    gcnt_p2 <= '0;
                end else begin
                    gcnt_p2 <= gcnt_p2 + 1'b1;
                end
            end else begin
                gcnt_p2 <= '0;
            end
            ic_q <= edge_det ? 16'd1 : sat_inc(ic_q);
        end
    end

    assign edge_det = filt_p2 ^ filt_p3;

    // Edges at or beyond T_MAX count as illegal; the timeout has already fired by then.
    always_comb begin
        is_short = edge_det && (ic_q >= T_MIN) && (ic_q < T_SL);
        is_long  = edge_det && (ic_q >= T_SL) && (ic_q < T_MAX);
        fault    = (edge_det && ((ic_q < T_MIN) || (ic_q >= T_MAX))) ||
                   (!edge_det && (ic_q == T_MAX));
    end

    always_comb begin
        phase_step = phase_q;
        if (is_long)
            phase_step = 1'b1;
        else if (is_short)
            phase_step = ~phase_q;
    end

    assign emit      = (is_long || is_short) && phase_step;
    assign bit_in    = filt_p2 ^ invert_q;
    assign byte_next = {shreg_q[6:0], bit_in};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        invert_d  = invert_q;
        phase_d   = phase_step;
        byte_done = 1'b0;
        lost_d    = 1'b0;
        if (!enable) begin
            state_d  = S_IDLE;
            shreg_d  = 8'd0;
            bitcnt_d = 3'd0;
            invert_d = 1'b0;
            phase_d  = 1'b0;
        end else if (state_q != S_IDLE && fault) begin
            state_d  = S_HUNT_PHASE;
            shreg_d  = 8'd0;
            bitcnt_d = 3'd0;
            invert_d = 1'b0;
            phase_d  = 1'b0;
            lost_d   = (state_q == S_DATA);
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HUNT_PHASE;
                    phase_d = 1'b0;
                end
                S_HUNT_PHASE: begin
                    if (is_long) begin
                        shreg_d = byte_next;
                        state_d = S_HUNT_SYNC;
                    end
                end
                S_HUNT_SYNC: begin
                    if (shreg_q == SYNC_BYTE) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else if (shreg_q == ~SYNC_BYTE) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                        invert_d = 1'b1;
                    end else if (emit) begin
                        shreg_d = byte_next;
                    end
                end
                S_DATA: begin
                    if (emit) begin
                        shreg_d  = byte_next;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7)
                            byte_done = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk18 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= 8'd0;
            bitcnt_q  <= 3'd0;
            invert_q  <= 1'b0;
            phase_q   <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            invert_q  <= invert_d;
            phase_q   <= phase_d;
            sync_lost <= lost_d;
        end
    end

    // An ack in the same cycle as a new byte retires the old one, so no overrun.
    always_ff @(posedge clk18 or negedge reset_n) begin
        if (!reset_n) begin
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (byte_done) begin
                byte_data  <= byte_next;
                byte_valid <= 1'b1;
            end else if (byte_ack) begin
                byte_valid <= 1'b0;
            end
            if (state_q == S_IDLE)
                overrun <= 1'b0;
            else if (byte_done && byte_valid && !byte_ack)
                overrun <= 1'b1;
        end
    end

    assign locked = (state_q == S_DATA);

endmodule

// File: tb/tb_tape_biphase_reader.sv
// Bench for tape_biphase_reader: biphase source model with selectable polarity,
// table of decode streams plus hand sequences for handshake, dropout, glitch and reset.
`timescale 1ns/1ps
module tb_tape_biphase_reader;

    localparam int HALF = 100;

    logic       clk18 = 1'b0;
    logic       reset_n, enable, tapein, byte_ack;
    logic       ack_auto, ack_man;
    logic [7:0] byte_data;
    logic       byte_valid, overrun, locked, sync_lost;

    int         checks = 0;
    int         errors = 0;
    int         lost_cnt = 0;
    logic [7:0] rxq[$];
    logic       pol;
    bit         auto_en;

    always #5 clk18 = ~clk18;

    assign byte_ack = ack_auto | ack_man;

    tape_biphase_reader #(
        .HALF_CYC (HALF),
        .GLITCH   (4),
        .SYNC_BYTE(8'hE6)
    ) dut (
        .clk18     (clk18),
        .reset_n   (reset_n),
        .enable    (enable),
        .tapein    (tapein),
        .byte_ack  (byte_ack),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .overrun   (overrun),
        .locked    (locked),
        .sync_lost (sync_lost)
    );

    typedef struct {
        logic       pol;
        int         pre;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t vt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk18);
    endtask

    // mode 0: plain cell; 1: ack exactly when the mid edge's byte lands; 2: 3-cycle glitch in first half
    task automatic send_bit(input logic b, input int mode);
        logic e;
        e = b ^ pol;
        tapein = ~e;
        if (mode == 2) begin
            wait_neg(40);
            tapein = e;
            wait_neg(3);
            tapein = ~e;
            wait_neg(HALF - 43);
        end else begin
            wait_neg(HALF);
        end
        tapein = e;
        if (mode == 1) begin
            repeat (6) @(posedge clk18);
            @(negedge clk18);
            ack_man = 1'b1;
            @(posedge clk18);
            @(negedge clk18);
            ack_man = 1'b0;
            wait_neg(HALF - 7);
        end else begin
            wait_neg(HALF);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int mode_all, input int mode_last);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i], (i == 0 && mode_last != 0) ? mode_last : mode_all);
    endtask

    task automatic sync_stream(input int pre);
        wait_neg(300);
        for (int i = 0; i < pre; i++)
            send_bit(1'b0, 0);
        send_byte(8'hE6, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk18);
        reset_n = 1'b0;
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(2);
    endtask

    // Consumer: when enabled, accept each byte with a one-cycle ack.
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(negedge clk18);
            if (ack_auto)
                ack_auto = 1'b0;
            else if (auto_en && byte_valid === 1'b1) begin
                rxq.push_back(byte_data);
                ack_auto = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk18);
            if (sync_lost === 1'b1)
                lost_cnt++;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        int rb, lb;
        logic [7:0] r0, r1;

        vt[0] = '{1'b0, 64, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        vt[1] = '{1'b1, 16, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        vt[2] = '{1'b0, 4,  8'h00, 8'hFF, 8'h00, 8'hFF};
        vt[3] = '{1'b1, 4,  8'h81, 8'h7E, 8'h81, 8'h7E};

        reset_n = 1'b0;
        enable  = 1'b0;
        tapein  = 1'b0;
        ack_man = 1'b0;
        auto_en = 1'b0;
        pol     = 1'b0;
        wait_neg(3);
        check("rst_byte_data", 32'(byte_data), 32'h0);
        check("rst_byte_valid", 32'(byte_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_sync_lost", 32'(sync_lost), 32'h0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Decode streams: normal and inverted polarity
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            pol     = vt[r].pol;
            auto_en = 1'b1;
            rb = rxq.size();
            lb = lost_cnt;
            sync_stream(vt[r].pre);
            check($sformatf("row%0d_locked", r), 32'(locked), 32'h1);
            send_byte(vt[r].b0, 0, 0);
            send_byte(vt[r].b1, 0, 0);
            r0 = (rxq.size() > rb) ? rxq[rb] : 8'hxx;
            r1 = (rxq.size() > rb + 1) ? rxq[rb + 1] : 8'hxx;
            check($sformatf("row%0d_count", r), 32'(rxq.size() - rb), 32'd2);
            check($sformatf("row%0d_byte0", r), 32'(r0), 32'(vt[r].exp0));
            check($sformatf("row%0d_byte1", r), 32'(r1), 32'(vt[r].exp1));
            check($sformatf("row%0d_overrun", r), 32'(overrun), 32'h0);
            check($sformatf("row%0d_nolost", r), 32'(lost_cnt - lb), 32'd0);
        end
        auto_en = 1'b0;
        pol     = 1'b0;
        wait_neg(4);

        // Overrun with byte_ack held low; IDLE clears it and keeps the byte
        apply_reset();
        sync_stream(4);
        send_byte(8'h3C, 0, 0);
        check("ovr_first_valid", 32'(byte_valid), 32'h1);
        check("ovr_first_data", 32'(byte_data), 32'h3C);
        check("ovr_first_flag", 32'(overrun), 32'h0);
        send_byte(8'hA5, 0, 0);
        check("ovr_second_data", 32'(byte_data), 32'hA5);
        check("ovr_second_valid", 32'(byte_valid), 32'h1);
        check("ovr_second_flag", 32'(overrun), 32'h1);
        enable = 1'b0;
        wait_neg(2);
        check("idle_overrun", 32'(overrun), 32'h0);
        check("idle_valid_kept", 32'(byte_valid), 32'h1);
        check("idle_data_kept", 32'(byte_data), 32'hA5);
        check("idle_locked", 32'(locked), 32'h0);
        enable = 1'b1;

        // Ack coincides with the next byte completing
        apply_reset();
        sync_stream(4);
        send_byte(8'h5A, 0, 0);
        check("coinc_first_valid", 32'(byte_valid), 32'h1);
        send_byte(8'hC3, 0, 1);
        check("coinc_valid", 32'(byte_valid), 32'h1);
        check("coinc_data", 32'(byte_data), 32'hC3);
        check("coinc_overrun", 32'(overrun), 32'h0);

        // Static line after lock: timeout, then re-lock
        apply_reset();
        auto_en = 1'b1;
        rb = rxq.size();
        lb = lost_cnt;
        sync_stream(4);
        send_byte(8'h3C, 0, 0);
        check("tmo_locked_before", 32'(locked), 32'h1);
        wait_neg(300);
        check("tmo_lost_pulses", 32'(lost_cnt - lb), 32'd1);
        check("tmo_locked_after", 32'(locked), 32'h0);
        sync_stream(4);
        check("tmo_relock", 32'(locked), 32'h1);
        send_byte(8'hA5, 0, 0);
        check("tmo_count", 32'(rxq.size() - rb), 32'd2);
        r1 = (rxq.size() > rb + 1) ? rxq[rb + 1] : 8'hxx;
        check("tmo_relock_byte", 32'(r1), 32'hA5);

        // Glitches rejected; a 30-cycle interval is illegal
        apply_reset();
        rb = rxq.size();
        lb = lost_cnt;
        sync_stream(4);
        send_byte(8'h96, 2, 0);
        r0 = (rxq.size() > rb) ? rxq[rb] : 8'hxx;
        check("glitch_count", 32'(rxq.size() - rb), 32'd1);
        check("glitch_byte", 32'(r0), 32'h96);
        check("glitch_locked", 32'(locked), 32'h1);
        check("glitch_nolost", 32'(lost_cnt - lb), 32'd0);
        wait_neg(60);
        tapein = ~tapein;
        wait_neg(30);
        tapein = ~tapein;
        wait_neg(20);
        check("short30_locked", 32'(locked), 32'h0);
        check("short30_lost", 32'(lost_cnt - lb), 32'd1);
        check("short30_nobyte", 32'(rxq.size() - rb), 32'd1);
        auto_en = 1'b0;
        wait_neg(4);

        // Reset mid-byte, then resume
        apply_reset();
        sync_stream(4);
        send_byte(8'h3C, 0, 0);
        check("rstmid_valid_before", 32'(byte_valid), 32'h1);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1, 0);
        reset_n = 1'b0;
        #1;
        check("rstmid_byte_data", 32'(byte_data), 32'h0);
        check("rstmid_byte_valid", 32'(byte_valid), 32'h0);
        check("rstmid_locked", 32'(locked), 32'h0);
        check("rstmid_overrun", 32'(overrun), 32'h0);
        check("rstmid_sync_lost", 32'(sync_lost), 32'h0);
        wait_neg(3);
        reset_n = 1'b1;
        auto_en = 1'b1;
        rb = rxq.size();
        sync_stream(4);
        check("rstmid_relock", 32'(locked), 32'h1);
        send_byte(8'hA5, 0, 0);
        r0 = (rxq.size() > rb) ? rxq[rb] : 8'hxx;
        check("rstmid_count", 32'(rxq.size() - rb), 32'd1);
        check("rstmid_byte", 32'(r0), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
